// File: rtl/lcd_frame_ctrl.sv
// HD44780 4-bit character LCD controller: power-on init, then
// two-line frame writes on start/busy/done or in auto-refresh.
module lcd_frame_ctrl #(
  parameter int CHARS          = 16,
  parameter int AUTO_REFRESH   = 0,
  parameter int SETUP_CYC      = 2,
  parameter int E_HIGH_CYC     = 12,
  parameter int NIB_GAP_CYC    = 50,
  parameter int CMD_WAIT_CYC   = 2000,
  parameter int CLEAR_WAIT_CYC = 82000,
  parameter int PWRUP_WAIT_CYC = 750000,
  parameter int INIT_WAIT_CYC  = 205000
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [8*CHARS-1:0] line1,
  input  logic [8*CHARS-1:0] line2,
  input  logic               start,
  output logic               busy,
  output logic               done,
  output logic               lcd_e,
  output logic               lcd_rs,
  output logic               lcd_w,
  output logic [3:0]         data
);

  function automatic int imax(
    input int a,
    input int b
  );
    return (a > b) ? a : b;
  endfunction

  localparam int MAXW = imax(
    imax(imax(PWRUP_WAIT_CYC, INIT_WAIT_CYC),
         imax(CLEAR_WAIT_CYC, CMD_WAIT_CYC)),
    imax(imax(SETUP_CYC, E_HIGH_CYC), NIB_GAP_CYC));
  localparam int CW     = $clog2(MAXW + 1);
  localparam int NBYTES = 2 * CHARS + 2;
  localparam int BW     = $clog2(NBYTES);

  typedef enum logic [2:0] {
    S_PWRUP,
    S_INIT_NIB,
    S_INIT_WAIT,
    S_CFG,
    S_IDLE,
    S_LATCH,
    S_WRITE,
    S_DONE
  } state_t;

  typedef enum logic [1:0] {
    P_SET,
    P_EHI,
    P_GAP,
    P_WAIT
  } phase_t;

  function automatic logic [7:0] cfg_byte(
    input logic [1:0] i
  );
    case (i)
      2'd0:    return 8'h28;
      2'd1:    return 8'h06;
      2'd2:    return 8'h0C;
      default: return 8'h01;
    endcase
  endfunction

  // Byte k of a frame: 0x80, line1 chars, 0xC0, line2 chars.
  function automatic logic [7:0] frame_byte(
    input logic [BW-1:0]      i,
    input logic [8*CHARS-1:0] a,
    input logic [8*CHARS-1:0] b
  );
    int                 k;
    logic [8*CHARS-1:0] t;
    k = int'(i);
    t = '0;
    if (k == 0) begin
      return 8'h80;
    end else if (k <= CHARS) begin
      t = a >> (8 * (CHARS - k));
      return t[7:0];
    end else if (k == CHARS + 1) begin
      return 8'hC0;
    end else if (k <= 2 * CHARS + 1) begin
      t = b >> (8 * (2 * CHARS + 1 - k));
      return t[7:0];
    end
    return 8'h00;
  endfunction

  function automatic logic frame_rs(
    input logic [BW-1:0] i
  );
    return !(int'(i) == 0 || int'(i) == CHARS + 1);
  endfunction

  state_t             state_q, state_d;
  phase_t             ph_q, ph_d;
  logic               lo_q, lo_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [1:0]         idx_q, idx_d;
  logic [BW-1:0]      byte_q, byte_d;
  logic [3:0]         nib_q, nib_d;
  logic               rs_q, rs_d;
  logic [8*CHARS-1:0] l1_q, l1_d;
  logic [8*CHARS-1:0] l2_q, l2_d;

  logic               go;
  logic [3:0]         go_nib;
  logic               go_rs;
  logic [7:0]         cur_b;
  logic               cur_rs;
  logic [7:0]         nxt_cfg;
  logic [7:0]         nxt_frm;
  logic               nxt_rs;
  logic [BW-1:0]      byte_inc;
  logic [1:0]         idx_inc;
  logic [CW-1:0]      lim;
  logic               set_end;
  logic               e_end;
  logic               gap_end;
  logic               wait_end;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_PWRUP;
      ph_q    <= P_WAIT;
      lo_q    <= 1'b0;
      cnt_q   <= '0;
      idx_q   <= '0;
      byte_q  <= '0;
      nib_q   <= 4'h0;
      rs_q    <= 1'b0;
      l1_q    <= '0;
      l2_q    <= '0;
    end else begin
      state_q <= state_d;
      ph_q    <= ph_d;
      lo_q    <= lo_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      byte_q  <= byte_d;
      nib_q   <= nib_d;
      rs_q    <= rs_d;
      l1_q    <= l1_d;
      l2_q    <= l2_d;
    end
  end

  always_comb begin
    byte_inc = BW'(byte_q + 1'b1);
    idx_inc  = 2'(idx_q + 2'd1);
    nxt_cfg  = cfg_byte(idx_inc);
    nxt_frm  = frame_byte(byte_inc, l1_q, l2_q);
    nxt_rs   = frame_rs(byte_inc);
    if (state_q == S_CFG) begin
      cur_b  = cfg_byte(idx_q);
      cur_rs = 1'b0;
    end else begin
      cur_b  = frame_byte(byte_q, l1_q, l2_q);
      cur_rs = frame_rs(byte_q);
    end
    if (state_q == S_INIT_WAIT) begin
      lim = (idx_q == 2'd0) ? CW'(INIT_WAIT_CYC - 1)
                            : CW'(CMD_WAIT_CYC - 1);
    end else if (state_q == S_CFG && idx_q == 2'd3) begin
      lim = CW'(CLEAR_WAIT_CYC - 1);
    end else begin
      lim = CW'(CMD_WAIT_CYC - 1);
    end
    set_end  = ph_q == P_SET && cnt_q == CW'(SETUP_CYC - 1);
    e_end    = ph_q == P_EHI && cnt_q == CW'(E_HIGH_CYC - 1);
    gap_end  = ph_q == P_GAP && cnt_q == CW'(NIB_GAP_CYC - 1);
    wait_end = ph_q == P_WAIT && cnt_q == lim;
  end

  always_comb begin
    state_d = state_q;
    ph_d    = ph_q;
    lo_d    = lo_q;
    cnt_d   = cnt_q + 1'b1;
    idx_d   = idx_q;
    byte_d  = byte_q;
    nib_d   = nib_q;
    rs_d    = rs_q;
    l1_d    = l1_q;
    l2_d    = l2_q;
    go      = 1'b0;
    go_nib  = 4'h0;
    go_rs   = 1'b0;
    unique case (state_q)
      S_PWRUP: begin
        if (cnt_q == CW'(PWRUP_WAIT_CYC - 1)) begin
          state_d = S_INIT_NIB;
          idx_d   = 2'd0;
          go      = 1'b1;
          go_nib  = 4'h3;
        end
      end
      S_INIT_NIB: begin
        if (set_end) begin
          ph_d  = P_EHI;
          cnt_d = '0;
        end else if (e_end) begin
          state_d = S_INIT_WAIT;
          ph_d    = P_WAIT;
          cnt_d   = '0;
        end
      end
      S_INIT_WAIT: begin
        if (wait_end) begin
          if (idx_q == 2'd3) begin
            state_d = S_CFG;
            idx_d   = 2'd0;
            lo_d    = 1'b0;
            go      = 1'b1;
            go_nib  = nxt_cfg[7:4];
          end else begin
            state_d = S_INIT_NIB;
            idx_d   = idx_inc;
            go      = 1'b1;
            go_nib  = (idx_q == 2'd2) ? 4'h2 : 4'h3;
          end
        end
      end
      S_CFG, S_WRITE: begin
        if (set_end) begin
          ph_d  = P_EHI;
          cnt_d = '0;
        end else if (e_end) begin
          ph_d  = lo_q ? P_WAIT : P_GAP;
          cnt_d = '0;
        end else if (gap_end) begin
          lo_d   = 1'b1;
          go     = 1'b1;
          go_nib = cur_b[3:0];
          go_rs  = cur_rs;
        end else if (wait_end) begin
          if (state_q == S_CFG) begin
            if (idx_q == 2'd3) begin
              state_d = (AUTO_REFRESH != 0) ? S_LATCH : S_IDLE;
            end else begin
              idx_d  = idx_inc;
              lo_d   = 1'b0;
              go     = 1'b1;
              go_nib = nxt_cfg[7:4];
            end
          end else if (byte_q == BW'(NBYTES - 1)) begin
            state_d = S_DONE;
          end else begin
            byte_d = byte_inc;
            lo_d   = 1'b0;
            go     = 1'b1;
            go_nib = nxt_frm[7:4];
            go_rs  = nxt_rs;
          end
        end
      end
      S_IDLE: begin
        cnt_d = cnt_q;
        if (start) begin
          state_d = S_LATCH;
        end
      end
      S_LATCH: begin
        l1_d    = line1;
        l2_d    = line2;
        state_d = S_WRITE;
        byte_d  = '0;
        lo_d    = 1'b0;
        go      = 1'b1;
        go_nib  = 4'h8;
      end
      S_DONE: begin
        state_d = (AUTO_REFRESH != 0) ? S_LATCH : S_IDLE;
      end
    endcase
    // Every nibble launch restarts the phase timer at setup.
    if (go) begin
      nib_d = go_nib;
      rs_d  = go_rs;
      ph_d  = P_SET;
      cnt_d = '0;
    end
  end

  always_comb begin
    lcd_e  = (state_q == S_INIT_NIB || state_q == S_CFG ||
              state_q == S_WRITE) && ph_q == P_EHI;
    lcd_rs = rs_q;
    lcd_w  = 1'b0;
    data   = nib_q;
    done   = state_q == S_DONE;
    busy   = (AUTO_REFRESH != 0) ||
             !(state_q == S_IDLE || state_q == S_DONE);
  end

endmodule

// File: doc/lcd_frame_ctrl.md
# lcd_frame_ctrl

Parametrised HD44780-compatible character-LCD controller for the board's 4-bit LCD interface (lcd_e, lcd_rs, lcd_w, data[3:0]). It runs the power-on initialisation and then writes two text lines of CHARS characters each to the display. Frames are written either on a start/busy/done handshake or continuously in auto-refresh mode. It sits between any text-producing logic and the LCD pins, and is the successor to the fixed two-line 16-character driver.

## Interface
- CHARS, 16: characters per line, legal range 1..40.
- AUTO_REFRESH, 0: when 1, frames are rewritten back-to-back and start is ignored.
- SETUP_CYC, 2: cycles that data and lcd_rs are stable before lcd_e rises.
- E_HIGH_CYC, 12: cycles lcd_e stays high per nibble.
- NIB_GAP_CYC, 50: cycles from the lcd_e fall of the upper nibble to the data change for the lower nibble.
- CMD_WAIT_CYC, 2000: wait after each byte and after init nibbles 2..4.
- CLEAR_WAIT_CYC, 82000: wait after the clear-display byte (0x01); replaces CMD_WAIT_CYC.
- PWRUP_WAIT_CYC, 750000: wait after reset before the first nibble.
- INIT_WAIT_CYC, 205000: wait after the first 0x3 nibble.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- reset  in  1  synchronous, active-high reset.
- line1  in  8*CHARS  top-line ASCII; character 0 (leftmost) is in bits [8*CHARS-1 -: 8].
- line2  in  8*CHARS  bottom-line ASCII, same ordering as line1.
- start  in  1  request a frame write; sampled only in IDLE.
- busy  out  1  high from reset through init, and during every frame write.
- done  out  1  one-cycle pulse when a frame write completes.
- lcd_e  out  1  LCD enable strobe.
- lcd_rs  out  1  0 = command byte, 1 = data byte.
- lcd_w  out  1  LCD read/write select; tied to 0 (write only).
- data  out  4  LCD data nibble, D7..D4.

## Operation
- Reset values: lcd_e=0, lcd_rs=0, lcd_w=0, data=0, busy=1, done=0. An assertion of reset in any state aborts the current operation and restarts at PWRUP.
- FSM states: PWRUP, INIT_NIB, INIT_WAIT, CFG, IDLE, LATCH, WRITE, DONE.
- INIT nibble sequence, each nibble with lcd_rs=0 and followed by its wait:
  - 0x3, then INIT_WAIT_CYC;
  - 0x3, then CMD_WAIT_CYC;
  - 0x3, then CMD_WAIT_CYC;
  - 0x2, then CMD_WAIT_CYC.
- CFG command bytes, in order: 0x28, 0x06, 0x0C, 0x01. The 0x01 byte is followed by CLEAR_WAIT_CYC.
- After CFG the FSM enters IDLE with busy=0. If AUTO_REFRESH=1 it goes straight to LATCH.
- IDLE: when start=1, go to LATCH. In every other state start is ignored and no request is queued.
- LATCH (1 cycle): snapshot line1 and line2 into internal registers. Input changes during WRITE do not affect the frame being written.
- WRITE byte sequence, 2*CHARS+2 bytes:
  - 0x80 (rs=0);
  - CHARS line1 bytes (rs=1), character 0 first;
  - 0xC0 (rs=0);
  - CHARS line2 bytes (rs=1).
- DONE: done=1 for one cycle. Next state is IDLE, or LATCH if AUTO_REFRESH=1.
- lcd_w is 0 in all states.

## Timing
- Byte write: upper nibble, then NIB_GAP_CYC, then lower nibble, then the post-byte wait.
- Nibble write, cycle by cycle from the data/rs update at cycle 0:
  - lcd_e rises at cycle SETUP_CYC;
  - lcd_e falls at cycle SETUP_CYC+E_HIGH_CYC;
  - data and rs hold until at least one cycle after the fall.
- Start latency: start is sampled high in IDLE at edge N. busy goes high at N+1 (LATCH) and the first data update occurs at N+2.
- Completion: done is high, and busy falls, in the cycle after the last byte's CMD_WAIT_CYC expires.
- AUTO_REFRESH=1: busy stays 1 permanently. done pulses once per frame.
- Counters must be wide enough for the largest wait parameter. The character index runs 0..CHARS-1 and must not wrap.
- Pulse counts, which the bench checks:
  - init: 12 lcd_e pulses (4 nibbles + 4 bytes);
  - frame: 4*CHARS+4 lcd_e pulses (68 for CHARS=16).

## Test plan
All scenarios use simulation parameters CHARS=4, PWRUP_WAIT_CYC=100, INIT_WAIT_CYC=40, CMD_WAIT_CYC=20, CLEAR_WAIT_CYC=60, unless a scenario states otherwise.

- Reset and init: hold reset for 3 cycles, then release.
  - Outputs are at their reset values during reset.
  - The first lcd_e rise occurs at cycle 100+SETUP_CYC after release.
  - Exactly 12 pulses, carrying nibbles 3,3,3,2,2,8,0,6,0,C,0,1.
  - busy falls after the clear wait.
- Frame write: line1="ABCD", line2="wxyz", then a 1-cycle start.
  - Bytes captured on the lcd_e falls are 0x80,41,42,43,44,C0,77,78,79,7A.
  - lcd_rs pattern is 0,1,1,1,1,0,1,1,1,1.
  - One done pulse, and busy is 0 afterwards.
- Snapshot and ignored start: change line1 to "ZZZZ" and pulse start during WRITE.
  - Captured bytes are still "ABCD".
  - No second frame follows; busy returns to 0.
- Reset mid-frame: assert reset after the 5th byte.
  - Outputs return to their reset values on the next cycle.
  - The full 12-pulse init sequence reruns.
- AUTO_REFRESH=1: with no start, 3 consecutive frames follow init.
  - 3 done pulses, spaced exactly one frame length apart.
  - busy is never 0.
- Timing checks on every nibble: SETUP_CYC=2 and E_HIGH_CYC=12 are measured cycle-exact. data, rs and lcd_w=0 are stable while lcd_e is high.
